// File: rtl/fmap_bram_writer.sv
// fmap_bram_writer
//   Write-side endpoint for a 64-bit feature-map BRAM port. Packs a
//   valid/ready stream of DATA_W-bit activations into WORD_W-bit words
//   (lane 0 = first sample) and writes them to consecutive addresses starting
//   at a programmed base address. A final partial word is zero-filled.
//
// Ports
//   clk          core clock
//   rst          asynchronous, active-low reset
//   start        1-cycle job start, honoured only when idle
//   base_addr    first word address of the job
//   num_samples  number of activations in the job (0 is legal)
//   s_valid      input sample valid
//   s_data       input sample
//   s_ready      writer accepts a sample (high for the whole RUN state)
//   bram_we      BRAM write enable, one cycle per packed word
//   bram_addr    BRAM word address (holds when bram_we=0)
//   bram_din     BRAM write data (holds when bram_we=0)
//   busy         job in progress (RUN or DRAIN)
//   done         1-cycle job-complete pulse
//   addr_wrap    sticky flag: write address wrapped past the top of memory
module fmap_bram_writer #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 64,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [WORD_W-1:0] bram_din,
  output logic              busy,
  output logic              done,
  output logic              addr_wrap
);

  localparam int LANES  = WORD_W / DATA_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [CNT_W-1:0]  remain_reg;
  logic [LANE_W-1:0] lane_reg;
  logic [WORD_W-1:0] word_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WORD_W-1:0] din_reg;
  logic              wrap_reg;

  logic              hs;
  logic              last_sample;
  logic              emit;
  logic [WORD_W-1:0] packed_word;

  assign hs          = s_valid && (state_reg == S_RUN);
  assign last_sample = hs && (remain_reg == CNT_W'(1));
  // A word is written when its last lane fills or the job runs out of samples.
  assign emit        = hs && ((lane_reg == LANE_W'(LANES - 1)) || last_sample);

  // The partial word with the incoming sample merged into the current lane;
  // this is what gets stored or written on a handshake.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign packed_word[gi*DATA_W +: DATA_W] =
        (lane_reg == LANE_W'(gi)) ? s_data : word_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      waddr_reg  <= '0;
      remain_reg <= '0;
      lane_reg   <= '0;
      word_reg   <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      din_reg    <= '0;
      wrap_reg   <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            waddr_reg  <= base_addr;
            remain_reg <= num_samples;
            lane_reg   <= '0;
            word_reg   <= '0;
            wrap_reg   <= 1'b0;
            state_reg  <= (num_samples == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (hs) begin
            remain_reg <= remain_reg - 1'b1;
            if (emit) begin
              we_reg    <= 1'b1;
              addr_reg  <= waddr_reg;
              din_reg   <= packed_word;
              waddr_reg <= waddr_reg + 1'b1;
              if (waddr_reg == '1) wrap_reg <= 1'b1;
              // Clearing here is what zero-fills the lanes of a short final word.
              word_reg  <= '0;
              lane_reg  <= '0;
            end else begin
              word_reg  <= packed_word;
              lane_reg  <= lane_reg + 1'b1;
            end
            if (last_sample) state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: state_reg <= S_DONE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Ready depends only on state: the write path is registered, so the writer
  // can take one sample every cycle for the whole job.
  assign s_ready   = (state_reg == S_RUN);
  assign busy      = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign done      = (state_reg == S_DONE);
  assign bram_we   = we_reg;
  assign bram_addr = addr_reg;
  assign bram_din  = din_reg;
  assign addr_wrap = wrap_reg;

endmodule

// File: tb/tb_fmap_bram_writer.sv
module tb_fmap_bram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [15:0] num_samples = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, bram_we, busy, done, addr_wrap;
  logic [11:0] bram_addr;
  logic [63:0] bram_din;

  fmap_bram_writer #(.DATA_W(8), .WORD_W(64), .ADDR_W(12), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_samples(num_samples), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .busy(busy), .done(done), .addr_wrap(addr_wrap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation of DUT activity, sampled on the falling edge.
  logic [11:0] cap_addr[$];
  logic [63:0] cap_din[$];
  int          cap_cyc[$];
  int          done_q[$];
  int          last_hs = -1;
  bit          busy_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (bram_we) begin
        cap_addr.push_back(bram_addr);
        cap_din.push_back(bram_din);
        cap_cyc.push_back(cyc);
      end
      if (done) done_q.push_back(cyc);
      if (s_valid && s_ready) last_hs = cyc;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the words a job must produce, from the packing rule alone.
  logic [11:0] exp_addr[$];
  logic [63:0] exp_din[$];
  bit          exp_wrap;

  task automatic model(input logic [11:0] base, input logic [7:0] d[$]);
    int nw;
    logic [63:0] w;
    exp_addr.delete();
    exp_din.delete();
    nw = (d.size() + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int k = 0; k < 8; k++)
        if (8*i + k < d.size()) w = w | (64'(d[8*i + k]) << (8*k));
      exp_din.push_back(w);
      exp_addr.push_back(12'((int'(base) + i) % 4096));
    end
    exp_wrap = (nw > 0) && (int'(base) + nw - 1 >= 4095);
  endtask

  task automatic do_job(input logic [11:0] base, input int n, input int pat,
                        input int gap, input bit poke);
    logic [7:0] dq[$];
    int idx, guard, start_cyc;
    bit acc;
    for (int i = 0; i < n; i++) begin
      if (pat == 0)      dq.push_back(8'(i + 1));
      else if (pat == 1) dq.push_back(8'(8'hAA + 8'h11 * i));
      else               dq.push_back(8'($urandom));
    end
    model(base, dq);
    cap_addr.delete(); cap_din.delete(); cap_cyc.delete(); done_q.delete();
    busy_seen = 1'b0;
    last_hs = -1;

    start = 1'b1; base_addr = base; num_samples = 16'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 12'h5A5; num_samples = 16'd99;
    chk("wrap_clear_on_start", 64'(addr_wrap), 64'd0);

    idx = 0; guard = 0;
    while (idx < n && guard < 4*n + 50) begin
      if (gap > 0 && $urandom_range(99) < gap) begin
        s_valid = 1'b0; s_data = 8'($urandom);
      end else begin
        s_valid = 1'b1; s_data = dq[idx];
      end
      if (poke && idx == 2) begin
        start = 1'b1; base_addr = 12'h555; num_samples = 16'd1;
      end
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) idx++;
      guard++;
    end
    s_valid = 1'b0;
    chk("samples_accepted", 64'(idx), 64'(n));

    guard = 0;
    while (done_q.size() == 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;

    chk("done_count", 64'(done_q.size()), 64'd1);
    chk("write_count", 64'(cap_din.size()), 64'(exp_din.size()));
    for (int i = 0; i < exp_din.size() && i < cap_din.size(); i++) begin
      chk($sformatf("waddr[%0d]", i), 64'(cap_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("wdata[%0d]", i), cap_din[i], exp_din[i]);
    end
    chk("addr_wrap", 64'(addr_wrap), 64'(exp_wrap));
    if (done_q.size() > 0) begin
      if (n > 0) begin
        chk("done_after_last_hs", 64'(done_q[0] - last_hs), 64'd2);
        if (cap_cyc.size() > 0)
          chk("we_after_last_hs", 64'(cap_cyc[cap_cyc.size()-1] - last_hs), 64'd1);
      end else begin
        chk("done_after_start", 64'(done_q[0] - start_cyc), 64'd1);
        chk("busy_zero_job", 64'(busy_seen), 64'd0);
      end
    end
    $display("job base=0x%03h n=%0d gap=%0d%% poke=%0d -> %0d writes, wrap=%0d",
             base, n, gap, poke, cap_din.size(), addr_wrap);
  endtask

  typedef struct {
    logic [11:0] base;
    int          n;
    int          pat;
    int          gap;
    int          exp_words;
    logic [63:0] exp_din0;
    logic [63:0] exp_din_last;
    logic [11:0] exp_addr_last;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{12'h010, 16, 0, 0,  2, 64'h0807060504030201, 64'h100F0E0D0C0B0A09, 12'h011, 1'b0};
    vecs[1] = '{12'h200, 3,  1, 0,  1, 64'h0000000000CCBBAA, 64'h0000000000CCBBAA, 12'h200, 1'b0};
    vecs[2] = '{12'h300, 0,  0, 0,  0, 64'h0,                64'h0,                12'h000, 1'b0};
    vecs[3] = '{12'h010, 16, 0, 40, 2, 64'h0807060504030201, 64'h100F0E0D0C0B0A09, 12'h011, 1'b0};
    vecs[4] = '{12'hFFF, 16, 0, 0,  2, 64'h0807060504030201, 64'h100F0E0D0C0B0A09, 12'h000, 1'b1};
    vecs[5] = '{12'h7F8, 9,  0, 0,  2, 64'h0807060504030201, 64'h0000000000000009, 12'h7F9, 1'b0};

    // Power-on reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({s_ready, bram_we, busy, done, addr_wrap}), 64'd0);
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_din", bram_din, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      do_job(vecs[v].base, vecs[v].n, vecs[v].pat, vecs[v].gap, 1'b0);
      chk($sformatf("vec%0d_words", v), 64'(cap_din.size()), 64'(vecs[v].exp_words));
      if (cap_din.size() > 0 && vecs[v].exp_words > 0) begin
        chk($sformatf("vec%0d_din0", v), cap_din[0], vecs[v].exp_din0);
        chk($sformatf("vec%0d_din_last", v), cap_din[cap_din.size()-1], vecs[v].exp_din_last);
        chk($sformatf("vec%0d_addr_last", v), 64'(cap_addr[cap_addr.size()-1]),
            64'(vecs[v].exp_addr_last));
      end
      chk($sformatf("vec%0d_wrap", v), 64'(addr_wrap), 64'(vecs[v].exp_wrap));
    end

    // Reset in the middle of a job: partial word dropped, no write.
    cap_din.delete();
    start = 1'b1; base_addr = 12'h100; num_samples = 16'd16;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h40 + i);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({s_ready, bram_we, busy, done, addr_wrap}), 64'd0);
    chk("midrst_addr", 64'(bram_addr), 64'd0);
    chk("midrst_din", bram_din, 64'd0);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_write", 64'(cap_din.size()), 64'd0);
    chk("midrst_idle", 64'({s_ready, busy, done}), 64'd0);
    // Fresh job after reset, with a stray start pulse during RUN.
    do_job(12'h020, 8, 0, 0, 1'b1);

    // Randomized jobs checked against the packing model.
    for (int j = 0; j < 12; j++) begin
      logic [11:0] b;
      b = ($urandom_range(3) == 0) ? 12'(12'hFFF - $urandom_range(3)) : 12'($urandom);
      do_job(b, $urandom_range(40), 2, $urandom_range(50), 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
